// File: rtl/sd_dev_phy_serdes.sv
// SD device-side PHY adaptation: oversampled phy clock edge detect, lane
// deserialiser/serialiser with valid/ready, SDR/DDR, lock tracking.
module sd_dev_phy_serdes #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned LOCK_EDGES   = 15,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_phy_clk,
  input  logic                  i_mode_ddr,
  input  logic                  i_bus_wide,
  output logic                  o_locked,
  output logic                  o_phy_posedge,
  output logic                  o_phy_negedge,
  input  logic                  i_sd_cmd_dir,
  input  logic                  i_sd_cmd_out,
  output logic                  o_sd_cmd_in,
  input  logic                  i_sd_data_dir,
  input  logic [7:0]            i_sd_data_out,
  input  logic                  i_sd_data_out_stb,
  output logic                  o_sd_data_out_rdy,
  output logic                  o_tx_underrun,
  output logic [7:0]            o_sd_data_in,
  output logic                  o_sd_data_in_stb,
  inout  wire                   io_phy_sd_cmd,
  inout  wire  [DATA_WIDTH-1:0] io_phy_sd_data
);

  localparam int unsigned SW = DATA_WIDTH + 2;
  localparam int unsigned EW = $clog2(LOCK_EDGES + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  logic [SW-1:0]         pins_c, sync1, sync2;
  logic                  phy_prev;
  logic                  pos_c, neg_c, cmd_s;
  logic [DATA_WIDTH-1:0] dat_s;
  logic                  mode_q, wide_q, dir_q;
  logic                  flush_c, timeout_c, clr_c;
  logic [EW-1:0]         edge_cnt;
  logic [IW-1:0]         idle_cnt;
  logic [3:0]            rx_cnt, grp_c, rx_sum_c;
  logic [7:0]            rx_shift, rx_nxt_c;
  logic                  rx_ev_c;
  logic                  cmd_drv;
  logic [7:0]            byte_reg, tx_shift, tx_src_c, tx_shift_nxt_c;
  logic                  byte_full;
  logic [2:0]            tx_left, gpb_c;
  logic [DATA_WIDTH-1:0] tx_drv, drv_c;
  logic                  launch_c, load_c, accept_c;

  // Phy clock, CMD and DAT share one synchroniser so samples stay edge-aligned
  assign pins_c = {i_phy_clk, io_phy_sd_cmd, io_phy_sd_data};
  assign pos_c  = sync2[SW-1] & ~phy_prev;
  assign neg_c  = ~sync2[SW-1] & phy_prev;
  assign cmd_s  = sync2[DATA_WIDTH];
  assign dat_s  = sync2[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1         <= '0;
      sync2         <= '0;
      phy_prev      <= 1'b0;
      o_phy_posedge <= 1'b0;
      o_phy_negedge <= 1'b0;
      mode_q        <= 1'b0;
      wide_q        <= 1'b0;
      dir_q         <= 1'b0;
    end else begin
      sync1         <= pins_c;
      sync2         <= sync1;
      phy_prev      <= sync2[SW-1];
      o_phy_posedge <= pos_c;
      o_phy_negedge <= neg_c;
      mode_q        <= i_mode_ddr;
      wide_q        <= i_bus_wide;
      dir_q         <= i_sd_data_dir;
    end
  end

  assign flush_c   = (i_mode_ddr ^ mode_q) | (i_bus_wide ^ wide_q) | (i_sd_data_dir ^ dir_q);
  assign timeout_c = (idle_cnt == IW'(IDLE_TIMEOUT - 1)) & ~pos_c;
  assign clr_c     = flush_c | timeout_c;

  // Lock acquisition on rising-edge count, loss on idle timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      idle_cnt <= '0;
      o_locked <= 1'b0;
    end else begin
      if (pos_c)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(IDLE_TIMEOUT))
        idle_cnt <= idle_cnt + IW'(1);
      if (timeout_c) begin
        edge_cnt <= '0;
        o_locked <= 1'b0;
      end else begin
        if (pos_c && edge_cnt != EW'(LOCK_EDGES))
          edge_cnt <= edge_cnt + EW'(1);
        if (edge_cnt == EW'(LOCK_EDGES))
          o_locked <= 1'b1;
      end
    end
  end

  assign grp_c    = i_bus_wide ? 4'(DATA_WIDTH) : 4'd1;
  assign gpb_c    = i_bus_wide ? 3'(8 / DATA_WIDTH - 1) : 3'd7;
  assign rx_nxt_c = i_bus_wide ? 8'({rx_shift, dat_s}) : {rx_shift[6:0], dat_s[0]};
  assign rx_sum_c = rx_cnt + grp_c;
  assign rx_ev_c  = ~i_sd_data_dir & (pos_c | (i_mode_ddr & neg_c));

  // Receive assembler: MSB-first groups, byte strobe when 8 bits collected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt           <= '0;
      rx_shift         <= '0;
      o_sd_data_in     <= '0;
      o_sd_data_in_stb <= 1'b0;
    end else begin
      o_sd_data_in_stb <= 1'b0;
      if (clr_c) begin
        rx_cnt <= '0;
      end else if (rx_ev_c) begin
        rx_shift <= rx_nxt_c;
        if (rx_sum_c >= 4'd8) begin
          rx_cnt           <= '0;
          o_sd_data_in     <= rx_nxt_c;
          o_sd_data_in_stb <= 1'b1;
        end else begin
          rx_cnt <= rx_sum_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sd_cmd_in <= 1'b1;
      cmd_drv     <= 1'b1;
    end else begin
      if (pos_c) o_sd_cmd_in <= cmd_s;
      if (neg_c) cmd_drv     <= i_sd_cmd_out;
    end
  end

  assign o_sd_data_out_rdy = o_locked & i_sd_data_dir & ~byte_full;
  assign accept_c = i_sd_data_out_stb & o_sd_data_out_rdy;
  assign launch_c = i_sd_data_dir & o_locked & (neg_c | (i_mode_ddr & pos_c));
  assign load_c   = launch_c & (tx_left == 3'd0);
  assign tx_src_c = load_c ? byte_reg : tx_shift;
  assign tx_shift_nxt_c = i_bus_wide ? (tx_src_c << DATA_WIDTH) : (tx_src_c << 1);

  always_comb begin
    drv_c = '1;
    if (i_bus_wide) drv_c    = tx_src_c[7 -: DATA_WIDTH];
    else            drv_c[0] = tx_src_c[7];
  end

  // Transmit: byte holding register feeding a group shifter; underrun drives 1s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_reg      <= '0;
      byte_full     <= 1'b0;
      tx_shift      <= '0;
      tx_left       <= '0;
      tx_drv        <= '1;
      o_tx_underrun <= 1'b0;
    end else begin
      o_tx_underrun <= 1'b0;
      if (clr_c) begin
        byte_full <= accept_c;
        tx_shift  <= '0;
        tx_left   <= '0;
        tx_drv    <= '1;
      end else begin
        if (launch_c) begin
          if (tx_left != 3'd0) begin
            tx_drv   <= drv_c;
            tx_shift <= tx_shift_nxt_c;
            tx_left  <= tx_left - 3'd1;
          end else if (byte_full) begin
            tx_drv   <= drv_c;
            tx_shift <= tx_shift_nxt_c;
            tx_left  <= gpb_c;
          end else begin
            tx_drv        <= '1;
            o_tx_underrun <= 1'b1;
          end
        end
        if (load_c && byte_full) byte_full <= 1'b0;
        if (accept_c)            byte_full <= 1'b1;
      end
      if (accept_c) byte_reg <= i_sd_data_out;
    end
  end

  // Pins release immediately while reset is held
  assign io_phy_sd_cmd = (rst_n && i_sd_cmd_dir) ? cmd_drv : 1'bz;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    assign io_phy_sd_data[i] = (rst_n && i_sd_data_dir && ((i == 0) || i_bus_wide)) ? tx_drv[i] : 1'bz;
  end

endmodule

// File: tb/tb_sd_dev_phy_serdes.sv
// Directed bench for sd_dev_phy_serdes: lock, SDR/DDR receive, wide transmit,
// flush on mode toggle and idle-timeout lock loss.
module tb_sd_dev_phy_serdes;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       phy_clk = 1'b0;
  logic       mode_ddr = 1'b0;
  logic       bus_wide = 1'b1;
  logic       cmd_dir = 1'b0;
  logic       cmd_out = 1'b1;
  logic       data_dir = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_stb = 1'b0;
  logic       locked, phy_pos, phy_neg, cmd_in, tx_rdy, tx_underrun, rx_stb;
  logic [7:0] rx_byte;
  wire        sd_cmd;
  wire  [3:0] sd_data;

  logic       host_cmd_en = 1'b1;
  logic       host_cmd = 1'b1;
  logic [3:0] host_dat_en = 4'h0;
  logic [3:0] host_dat = 4'h0;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] rx_q[$];
  logic [3:0] tx_q[$];
  int         underruns = 0;

  sd_dev_phy_serdes #(.DATA_WIDTH(4), .LOCK_EDGES(15), .IDLE_TIMEOUT(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_phy_clk         (phy_clk),
    .i_mode_ddr        (mode_ddr),
    .i_bus_wide        (bus_wide),
    .o_locked          (locked),
    .o_phy_posedge     (phy_pos),
    .o_phy_negedge     (phy_neg),
    .i_sd_cmd_dir      (cmd_dir),
    .i_sd_cmd_out      (cmd_out),
    .o_sd_cmd_in       (cmd_in),
    .i_sd_data_dir     (data_dir),
    .i_sd_data_out     (tx_byte),
    .i_sd_data_out_stb (tx_stb),
    .o_sd_data_out_rdy (tx_rdy),
    .o_tx_underrun     (tx_underrun),
    .o_sd_data_in      (rx_byte),
    .o_sd_data_in_stb  (rx_stb),
    .io_phy_sd_cmd     (sd_cmd),
    .io_phy_sd_data    (sd_data)
  );

  // Host-side pin drivers; undriven pins settle low so a released lane reads 0
  pulldown (sd_cmd);
  pulldown (sd_data[0]);
  pulldown (sd_data[1]);
  pulldown (sd_data[2]);
  pulldown (sd_data[3]);
  assign sd_cmd = host_cmd_en ? host_cmd : 1'bz;
  for (genvar i = 0; i < 4; i++) begin : g_host
    assign sd_data[i] = host_dat_en[i] ? host_dat[i] : 1'bz;
  end

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_stb)      rx_q.push_back(rx_byte);
    if (phy_neg)     tx_q.push_back(sd_data);
    if (tx_underrun) underruns = underruns + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One phy half period (4 clk); data set before the call has 2 clk setup
  task automatic phy_edge(input logic level);
    tick(2);
    phy_clk = level;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    tx_stb  = 1'b1;
    tx_byte = b;
    n = 0;
    while (!tx_rdy && n < 200) begin
      tick(1);
      n++;
    end
    check("tx_rdy_wait", 32'(tx_rdy), 32'd1);
    tick(1);
    tx_stb = 1'b0;
  endtask

  function automatic logic [7:0] rx_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 8'hEE;
  endfunction

  function automatic logic [3:0] tx_at(input int idx);
    if (idx < tx_q.size()) return tx_q[idx];
    return 4'h0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rx_base, tx_base, u_base;
    logic [7:0] pat;
    logic [3:0] exp_nib[5];

    // Reset values
    tick(3);
    check("rst_locked", 32'(locked), 0);
    check("rst_posedge", 32'(phy_pos), 0);
    check("rst_negedge", 32'(phy_neg), 0);
    check("rst_data_in", 32'(rx_byte), 0);
    check("rst_stb", 32'(rx_stb), 0);
    check("rst_underrun", 32'(tx_underrun), 0);
    check("rst_cmd_in", 32'(cmd_in), 1);
    check("rst_rdy", 32'(tx_rdy), 0);
    rst_n = 1'b1;
    tick(2);

    // Lock after 15 rising edges at clk/8
    repeat (14) begin
      phy_edge(1'b1);
      phy_edge(1'b0);
    end
    check("lock_after_14", 32'(locked), 0);
    phy_edge(1'b1);
    tick(1);
    check("posedge_pulse", 32'(phy_pos), 1);
    check("lock_15_early", 32'(locked), 0);
    tick(1);
    check("lock_15", 32'(locked), 1);

    // SDR wide receive, plus CMD sampling on rising edges
    mode_ddr = 1'b1; tick(1);
    mode_ddr = 1'b0; tick(1);
    rx_base     = rx_q.size();
    host_dat_en = 4'hF;
    host_dat    = 4'hA;
    host_cmd    = 1'b0;
    phy_edge(1'b0);
    phy_edge(1'b1);
    host_dat = 4'h5;
    host_cmd = 1'b1;
    phy_edge(1'b0);
    check("cmd_in_low", 32'(cmd_in), 0);
    phy_edge(1'b1);
    tick(4);
    check("cmd_in_high", 32'(cmd_in), 1);
    check("rx_sdr_count", 32'(rx_q.size() - rx_base), 1);
    check("rx_sdr_byte", 32'(rx_at(rx_base)), 32'hA5);

    // SDR wide transmit of two bytes then underrun; CMD driven on falling edges
    host_dat_en = 4'h0;
    host_cmd_en = 1'b0;
    cmd_dir     = 1'b1;
    cmd_out     = 1'b0;
    data_dir    = 1'b1;
    tick(1);
    check("tx_rdy_idle", 32'(tx_rdy), 1);
    check("cmd_drive_hold", 32'(sd_cmd), 1);
    tx_base = tx_q.size();
    u_base  = underruns;
    fork
      begin
        repeat (5) begin
          phy_edge(1'b0);
          phy_edge(1'b1);
        end
      end
      begin
        send_byte(8'h3C);
        send_byte(8'h81);
      end
    join
    exp_nib = '{4'h3, 4'hC, 4'h8, 4'h1, 4'hF};
    for (int k = 0; k < 5; k++)
      check($sformatf("tx_nibble_%0d", k), 32'(tx_at(tx_base + k)), 32'(exp_nib[k]));
    check("tx_underrun_count", 32'(underruns - u_base), 1);
    check("cmd_drive", 32'(sd_cmd), 0);
    cmd_dir = 1'b0;

    // Bus-width toggle after one nibble discards it
    data_dir = 1'b0;
    tick(1);
    host_dat_en = 4'hF;
    host_dat    = 4'h7;
    rx_base     = rx_q.size();
    phy_edge(1'b0);
    phy_edge(1'b1);
    tick(2);
    bus_wide = 1'b0; tick(1);
    bus_wide = 1'b1; tick(1);
    host_dat = 4'hE;
    phy_edge(1'b0);
    phy_edge(1'b1);
    host_dat = 4'h2;
    phy_edge(1'b0);
    phy_edge(1'b1);
    tick(4);
    check("flush_count", 32'(rx_q.size() - rx_base), 1);
    check("flush_byte", 32'(rx_at(rx_base)), 32'hE2);

    // DDR narrow receive, one bit per edge on lane 0
    phy_edge(1'b0);
    mode_ddr    = 1'b1;
    bus_wide    = 1'b0;
    host_dat_en = 4'b0001;
    tick(2);
    rx_base = rx_q.size();
    pat     = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      host_dat[0] = pat[7-i];
      phy_edge((i % 2) == 0);
    end
    tick(4);
    check("ddr_count", 32'(rx_q.size() - rx_base), 1);
    check("ddr_byte", 32'(rx_at(rx_base)), 32'hB2);
    check("ddr_lanes_hi", 32'(sd_data[3:1]), 0);

    // Narrow transmit leaves lanes 3:1 undriven
    host_dat_en = 4'h0;
    data_dir    = 1'b1;
    tick(2);
    check("narrow_tx_pins", 32'(sd_data), 32'h1);
    check("narrow_rdy", 32'(tx_rdy), 1);

    // Idle timeout drops lock and discards a partial byte
    data_dir = 1'b0;
    mode_ddr = 1'b0;
    bus_wide = 1'b1;
    tick(1);
    host_dat_en = 4'hF;
    host_dat    = 4'h9;
    rx_base     = rx_q.size();
    phy_edge(1'b1);
    tick(2);
    check("lock_before_idle", 32'(locked), 1);
    tick(70);
    check("lock_after_idle", 32'(locked), 0);
    check("idle_no_stb", 32'(rx_q.size() - rx_base), 0);
    phy_edge(1'b0);
    host_dat = 4'h3;
    phy_edge(1'b1);
    tick(4);
    check("idle_partial_dropped", 32'(rx_q.size() - rx_base), 0);
    host_dat_en = 4'h0;
    data_dir    = 1'b1;
    tick(2);
    check("idle_rdy", 32'(tx_rdy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
